// File: rtl/pixel_to_complex_pkg.sv
// Shared constants for the frequency-domain filter chain.
// Image geometry, float32 field layout and complex sample layout are
// reused by the later stages (multiplier, IFFT wrapper).
package pixel_to_complex_pkg;

    localparam int IMG_W           = 128;
    localparam int IMG_H           = 128;
    localparam int PIX_PER_BEAT    = 8;
    localparam int PIX_W           = 8;
    localparam int AXIS_DW         = 64;
    localparam int FRAME_SAMPLES   = IMG_W * IMG_H;
    localparam int BEATS_PER_FRAME = FRAME_SAMPLES / PIX_PER_BEAT;

    // float32 fields
    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_EXP_W    = 8;
    localparam int FP32_MANT_W   = 23;
    localparam int FP32_EXP_BIAS = 127;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    // Complex sample: real in the upper word, imag in the lower word
    localparam int REAL_MSB = 63;
    localparam int REAL_LSB = 32;
    localparam int IMAG_MSB = 31;
    localparam int IMAG_LSB = 0;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        fp32_t re;
        fp32_t im;
    } cplx_t;

endpackage

// File: rtl/pixel_to_complex_if.sv
// Stream bundle (valid/ready/data/last) used on both sides of the stage.
interface pixel_to_complex_if import pixel_to_complex_pkg::*; ();

    logic               tvalid;
    logic               tready;
    logic [AXIS_DW-1:0] tdata;
    logic               tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/pixel_to_complex_u8_to_fp32.sv
// Exact unsigned 8-bit integer to float32 conversion.
// Every u8 fits in the 24-bit significand, so no rounding is ever needed.
module u8_to_fp32 import pixel_to_complex_pkg::*; (
    input  logic [PIX_W-1:0] i_pix,
    output logic [31:0]      o_fp
);

    logic [2:0]  w_msb;
    logic [23:0] w_norm;

    // Priority encoder: index of the highest set bit
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < PIX_W; i++) begin
            if (i_pix[i]) w_msb = 3'(i);
        end
    end

    // Normalise so the leading one sits at bit 23 (hidden bit), then pack
    always_comb begin
        w_norm = {16'b0, i_pix} << (5'd23 - {2'b0, w_msb});
        if (i_pix == '0)
            o_fp = FP32_ZERO;
        else
            o_fp = {1'b0, 8'(FP32_EXP_BIAS) + {5'b0, w_msb}, w_norm[FP32_MANT_W-1:0]};
    end

endmodule

// File: rtl/pixel_to_complex.sv
// Pixel unpacker: 8 packed u8 pixels per beat in, one {real, imag} float32
// complex sample per cycle out, with frame-end tlast generation.
// Optional build macro CENTER_SHIFT_EN negates the real part on odd
// (row+col) to move DC to the image centre.
module pixel_to_complex import pixel_to_complex_pkg::*; #(
    parameter int IMG_W        = pixel_to_complex_pkg::IMG_W,
    parameter int IMG_H        = pixel_to_complex_pkg::IMG_H,
    parameter int PIX_PER_BEAT = pixel_to_complex_pkg::PIX_PER_BEAT
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    pixel_to_complex_if.slave         s_axis,
    pixel_to_complex_if.master        m_axis,
    output logic                      frame_err
);

    localparam int SCW = $clog2(IMG_W * IMG_H);
    localparam int BCW = $clog2(IMG_W * IMG_H / PIX_PER_BEAT);
    localparam int LW  = $clog2(PIX_PER_BEAT);
    localparam logic [SCW-1:0] LAST_SAMPLE = SCW'(IMG_W * IMG_H - 1);
    localparam logic [BCW-1:0] LAST_BEAT   = BCW'(IMG_W * IMG_H / PIX_PER_BEAT - 1);
    localparam logic [LW-1:0]  LAST_LANE   = LW'(PIX_PER_BEAT - 1);

    logic [AXIS_DW-1:0] r_buf;
    logic               r_buf_valid;
    logic               r_buf_last;
    logic [LW-1:0]      r_lane;
    logic [SCW-1:0]     r_sample_cnt;
    logic [BCW-1:0]     r_beat_cnt;
    logic               r_out_valid;
    logic               r_out_last;
    cplx_t              r_out_data;
    logic               r_frame_err;

    logic               w_out_load;
    logic               w_beat_done;
    logic               w_s_hs;
    logic [PIX_W-1:0]   w_pix;
    logic [31:0]        w_fp;
    logic               w_sign;
    logic [31:0]        w_real;

    // The buffer frees in the same cycle its last lane moves to the output,
    // so a waiting beat loads back-to-back with no bubble.
    assign w_out_load  = r_buf_valid && (!r_out_valid || m_axis.tready);
    assign w_beat_done = w_out_load && (r_lane == LAST_LANE);
    assign s_axis.tready = !r_buf_valid || w_beat_done;
    assign w_s_hs      = s_axis.tvalid && s_axis.tready;

    assign w_pix = r_buf[PIX_W * r_lane +: PIX_W];

    u8_to_fp32 u_conv (
        .i_pix (w_pix),
        .o_fp  (w_fp)
    );

`ifdef CENTER_SHIFT_EN
    localparam int CW = $clog2(IMG_W);
    // (-1)^(row+col): row[0] is the bit just above the column field
    assign w_sign = (w_pix != '0) && (r_sample_cnt[CW] ^ r_sample_cnt[0]);
`else
    assign w_sign = 1'b0;
`endif
    assign w_real = w_fp | {w_sign, 31'b0};

    // Beat buffer: load on input handshake, release after lane 7 is taken
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_buf_last  <= 1'b0;
        end else if (w_s_hs) begin
            r_buf       <= s_axis.tdata;
            r_buf_valid <= 1'b1;
            r_buf_last  <= s_axis.tlast;
        end else if (w_beat_done) begin
            r_buf_valid <= 1'b0;
        end
    end

    // Lane, sample and beat counters; an input tlast re-aligns the frame
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_lane       <= '0;
            r_sample_cnt <= '0;
            r_beat_cnt   <= '0;
        end else if (w_out_load) begin
            r_lane <= r_lane + 1'b1;
            if (w_beat_done && r_buf_last) begin
                r_sample_cnt <= '0;
                r_beat_cnt   <= '0;
            end else begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
                if (w_beat_done) r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    // Sticky framing error: input tlast and the beat count disagree
    always_ff @(posedge aclk) begin
        if (!aresetn)
            r_frame_err <= 1'b0;
        else if (w_beat_done && (r_buf_last != (r_beat_cnt == LAST_BEAT)))
            r_frame_err <= 1'b1;
    end

    // Output register: held while the consumer stalls
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= '{re: w_real, im: FP32_ZERO};
            r_out_last  <= (r_sample_cnt == LAST_SAMPLE) || (w_beat_done && r_buf_last);
        end else if (m_axis.tready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign m_axis.tvalid = r_out_valid;
    assign m_axis.tdata  = r_out_data;
    assign m_axis.tlast  = r_out_last;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_pixel_to_complex.sv
// Directed bench for pixel_to_complex: conversion table, single beat,
// early tlast, all-0xFF, mid-beat reset and two throttled full frames.
module tb_pixel_to_complex;
    import pixel_to_complex_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic frame_err;

    pixel_to_complex_if s_if ();
    pixel_to_complex_if m_if ();

    pixel_to_complex dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .frame_err (frame_err)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [7:0] pix; logic [31:0] f; } conv_vec_t;
    typedef struct { logic [63:0] data; logic last; } samp_t;

    conv_vec_t   tbl [16];
    logic [31:0] exp0 [8];
    samp_t       expq [$];
    int          n_checks = 0;
    int          n_errs = 0;
    logic [13:0] mcnt;
    logic [10:0] mbeat;
    logic        merr;
    int          out_total;
    int          last_seen;
    int          n_lasts;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pat_idx(input int mode, input int bi, input int lane);
        if (mode == 1) return 15;
        if (mode == 2) return (bi * 8 + lane) % 16;
        return (bi * 3 + lane * 5 + bi / 16) % 16;
    endfunction

    function automatic logic [63:0] beat_data(input int mode, input int bi);
        logic [63:0] d;
        d = '0;
        for (int l = 0; l < 8; l++) d[l*8 +: 8] = tbl[pat_idx(mode, bi, l)].pix;
        return d;
    endfunction

    // Reference model of the framing rules, fed per accepted beat
    task automatic model_push(input int mode, input int bi, input logic last);
        samp_t e;
        logic [31:0] f;
        int idx;
        for (int l = 0; l < 8; l++) begin
            idx = pat_idx(mode, bi, l);
            f = tbl[idx].f;
`ifdef CENTER_SHIFT_EN
            if (tbl[idx].pix != 8'd0 && (mcnt[7] ^ mcnt[0])) f[31] = 1'b1;
`endif
            e.data = {f, 32'h0};
            e.last = (mcnt == 14'h3FFF) || (l == 7 && last);
            expq.push_back(e);
            if (l == 7 && last) mcnt = '0;
            else mcnt = mcnt + 14'd1;
        end
        if (last != (mbeat == 11'h7FF)) merr = 1'b1;
        mbeat = last ? 11'd0 : mbeat + 11'd1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        @(posedge aclk); #1;
        check("reset_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("reset_m_tdata", m_if.tdata, 64'd0);
        check("reset_m_tlast", 64'(m_if.tlast), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        check("reset_s_tready", 64'(s_if.tready), 64'd1);
        aresetn = 1'b1;
        mcnt = '0; mbeat = '0; merr = 1'b0;
        expq.delete();
        out_total = 0; last_seen = -1; n_lasts = 0;
    endtask

    // Drive nbeats, score every output sample, check hold-while-stalled.
    // stop_outs > 0 returns right after that many outputs were taken.
    task automatic run_stream(input int nbeats, input int mode, input int last_mod,
                              input bit thr, input int stop_outs);
        int bi = 0, outs = 0, cyc = 0;
        logic pv = 1'b0, pl = 1'b0, in_hs, out_hs;
        logic [63:0] pd = '0;
        samp_t e;
        while ((bi < nbeats || expq.size() > 0) && cyc < nbeats * 32 + 50) begin
            s_if.tvalid = (bi < nbeats);
            s_if.tdata  = beat_data(mode, bi);
            s_if.tlast  = (last_mod > 0) && ((bi % last_mod) == last_mod - 1);
            m_if.tready = thr ? ($urandom_range(0, 7) != 0) : 1'b1;
            @(negedge aclk);
            in_hs  = s_if.tvalid && s_if.tready;
            out_hs = m_if.tvalid && m_if.tready;
            if (pv) begin
                check("hold_valid", 64'(m_if.tvalid), 64'd1);
                check("hold_data", m_if.tdata, pd);
                check("hold_last", 64'(m_if.tlast), 64'(pl));
            end
            pv = m_if.tvalid && !m_if.tready;
            pd = m_if.tdata;
            pl = m_if.tlast;
            if (out_hs) begin
                if (expq.size() == 0) begin
                    check("extra_sample", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    check("sample_data", m_if.tdata, e.data);
                    check("sample_last", 64'(m_if.tlast), 64'(e.last));
                end
                if (m_if.tlast) begin last_seen = out_total; n_lasts++; end
                out_total++;
                outs++;
            end
            if (in_hs) begin
                model_push(mode, bi, s_if.tlast);
                bi++;
            end
            @(posedge aclk); #1;
            cyc++;
            if (stop_outs > 0 && outs == stop_outs) break;
        end
        s_if.tvalid = 1'b0;
        if (stop_outs <= 0) begin
            check("stream_drained", {62'd0, bi == nbeats, expq.size() == 0}, 64'd3);
            check("idle_after", 64'(m_if.tvalid), 64'd0);
            check("frame_err", 64'(frame_err), 64'(merr));
        end else begin
            check("stop_reached", 64'(outs), 64'(stop_outs));
        end
    endtask

    initial begin
        int lowcnt;
        logic [31:0] e;
        tbl[0]  = '{8'd0,   32'h00000000};
        tbl[1]  = '{8'd1,   32'h3F800000};
        tbl[2]  = '{8'd2,   32'h40000000};
        tbl[3]  = '{8'd3,   32'h40400000};
        tbl[4]  = '{8'd4,   32'h40800000};
        tbl[5]  = '{8'd5,   32'h40A00000};
        tbl[6]  = '{8'd7,   32'h40E00000};
        tbl[7]  = '{8'd8,   32'h41000000};
        tbl[8]  = '{8'd15,  32'h41700000};
        tbl[9]  = '{8'd16,  32'h41800000};
        tbl[10] = '{8'd100, 32'h42C80000};
        tbl[11] = '{8'd127, 32'h42FE0000};
        tbl[12] = '{8'd128, 32'h43000000};
        tbl[13] = '{8'd129, 32'h43010000};
        tbl[14] = '{8'd200, 32'h43480000};
        tbl[15] = '{8'd255, 32'h437F0000};
        exp0 = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

        do_reset();

        // Single beat 0..7: latency, values, s_ready low 7 of 8 cycles
        s_if.tvalid = 1'b1;
        s_if.tdata  = 64'h0706050403020100;
        s_if.tlast  = 1'b0;
        @(negedge aclk);
        check("s_ready_idle", 64'(s_if.tready), 64'd1);
        @(posedge aclk); #1;
        s_if.tvalid = 1'b0;
        lowcnt = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge aclk);
            if (c < 8 && !s_if.tready) lowcnt++;
            if (c == 0) begin
                check("first_latency", 64'(m_if.tvalid), 64'd0);
            end else begin
                e = exp0[c-1];
`ifdef CENTER_SHIFT_EN
                if ((c - 1) % 2 == 1) e[31] = 1'b1;
`endif
                check("beat0_valid", 64'(m_if.tvalid), 64'd1);
                check("beat0_data", m_if.tdata, {e, 32'h0});
                check("beat0_last", 64'(m_if.tlast), 64'd0);
            end
            @(posedge aclk); #1;
        end
        check("s_ready_low_cycles", 64'(lowcnt), 64'd7);

        // Conversion table over two beats
        do_reset();
        run_stream(2, 2, 0, 1'b0, 0);

        // Early tlast on beat 99, then the frame restarts at sample 0
        do_reset();
        run_stream(100, 0, 100, 1'b0, 0);
        check("early_last_idx", 64'(last_seen), 64'd799);
        check("early_frame_err", 64'(frame_err), 64'd1);
        run_stream(2, 1, 0, 1'b0, 0);
        check("early_err_sticky", 64'(frame_err), 64'd1);

        // All 0xFF across more than one row (covers samples 0, 1, 128)
        do_reset();
        run_stream(17, 1, 0, 1'b0, 0);

        // Reset after lane 3 has been taken; next beat restarts from lane 0
        do_reset();
        run_stream(1, 0, 0, 1'b0, 4);
        do_reset();
        run_stream(1, 1, 0, 1'b0, 0);

        // Two full frames with random downstream throttling
        do_reset();
        run_stream(4096, 0, 2048, 1'b1, 0);
        check("frames_tlast_count", 64'(n_lasts), 64'd2);
        check("frames_last_idx", 64'(last_seen), 64'd32767);
        check("frames_sample_total", 64'(out_total), 64'd32768);
        check("frames_no_err", 64'(frame_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
